// File: rtl/sfifo_if_mc.sv
// sfifo_if_mc: Wishbone slave that connects the CPU to the servo sync-FIFO, a
// base-period tick counter, DOUT set/reset pulses, DIN level and rising-edge
// capture, and ADC_N sample channels. Reads from an empty FIFO wait for data
// for a limited time. If no word arrives, the read is acked with zero and a
// sticky timeout flag is set.
module sfifo_if_mc #(
    parameter int WB_AW       = 7,
    parameter int WB_DW       = 32,
    parameter int SFIFO_DW    = 16,
    parameter int DOUT_N      = 8,
    parameter int DIN_W       = 16,
    parameter int ADC_N       = 2,
    parameter int ADC_W       = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [WB_AW-1:2]       wb_adr_i,
    input  logic [WB_DW-1:0]       wb_dat_i,
    output logic [WB_DW-1:0]       wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   sfifo_rd_o,
    input  logic                   sfifo_empty_i,
    input  logic [SFIFO_DW-1:0]    sfifo_di,
    input  logic                   sfifo_bp_tick_i,
    output logic [DOUT_N-1:0]      dout_set_o,
    output logic [DOUT_N-1:0]      dout_rst_o,
    input  logic [DIN_W-1:0]       din_i,
    input  logic [ADC_N*ADC_W-1:0] adc_i
);

    localparam int AW   = WB_AW - 2;
    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    localparam logic [AW-1:0] ADDR_BP   = AW'(0);
    localparam logic [AW-1:0] ADDR_STAT = AW'(1);
    localparam logic [AW-1:0] ADDR_DI   = AW'(2);
    localparam logic [AW-1:0] ADDR_DOUT = AW'(3);
    localparam logic [AW-1:0] ADDR_DIN  = AW'(4);
    localparam logic [AW-1:0] ADDR_DINR = AW'(5);
    localparam logic [AW-1:0] ADDR_ADC0 = AW'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic              to_flag;

    logic              bp_meta;
    logic              bp_sync;
    logic              bp_prev;
    logic [31:0]       bp_cnt;

    logic [DIN_W-1:0]  din_meta;
    logic [DIN_W-1:0]  din_sync;
    logic [DIN_W-1:0]  din_prev;
    logic [DIN_W-1:0]  dinr;

    logic              bus_req;
    logic              accept;
    logic              di_read;
    logic              wr_accept;
    logic              to_clr;
    logic [DIN_W-1:0]  dinr_clr;
    logic              dout_hit;
    logic [DOUT_N-1:0] dout_onehot;
    logic [WB_DW-1:0]  rd_data;
    logic [WB_DW-1:0]  head_data;
    logic              unused_bits;

    assign bus_req   = wb_cyc_i & wb_stb_i;
    assign accept    = bus_req & ~wb_ack_o & (state == S_IDLE);
    assign di_read   = accept & ~wb_we_i & (wb_adr_i == ADDR_DI);
    assign wr_accept = accept & wb_we_i;

    assign to_clr    = wr_accept & (wb_adr_i == ADDR_STAT) & wb_sel_i[0] & wb_dat_i[1];
    assign dinr_clr  = (wr_accept && (wb_adr_i == ADDR_DINR) && wb_sel_i[0])
                       ? wb_dat_i[DIN_W-1:0] : '0;

    assign dout_hit    = wr_accept & (wb_adr_i == ADDR_DOUT) & wb_sel_i[3] & wb_dat_i[31]
                         & ({1'b0, wb_dat_i[29:24]} < 7'(DOUT_N));
    assign dout_onehot = DOUT_N'(1) << wb_dat_i[29:24];

    // FIFO head left-aligned in the data word; low bits are zero.
    assign head_data = WB_DW'(sfifo_di) << (WB_DW - SFIFO_DW);

    assign unused_bits = ^{wb_sel_i, wb_dat_i};

    // Register read multiplexer for all single-cycle (non-FIFO) reads.
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADDR_BP:   rd_data = WB_DW'(bp_cnt);
            ADDR_STAT: begin
                rd_data[0] = sfifo_empty_i;
                rd_data[1] = to_flag;
            end
            ADDR_DIN:  rd_data[DIN_W-1:0] = din_sync;
            ADDR_DINR: rd_data[DIN_W-1:0] = dinr;
            default:   rd_data = '0;
        endcase
        for (int k = 0; k < ADC_N; k++) begin
            if (wb_adr_i == (ADDR_ADC0 + AW'(k))) begin
                rd_data[ADC_W-1:0] = adc_i[k*ADC_W +: ADC_W];
            end
        end
    end

    // Bus handshake and FIFO read FSM. Ack, pop and DOUT pulses are all single-cycle outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            sfifo_rd_o <= 1'b0;
            to_cnt     <= '0;
            to_flag    <= 1'b0;
            dout_set_o <= '0;
            dout_rst_o <= '0;
        end else begin
            wb_ack_o   <= 1'b0;
            sfifo_rd_o <= 1'b0;
            dout_set_o <= '0;
            dout_rst_o <= '0;
            if (to_clr) begin
                to_flag <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (di_read) begin
                        if (!sfifo_empty_i) begin
                            wb_ack_o   <= 1'b1;
                            wb_dat_o   <= head_data;
                            sfifo_rd_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            to_cnt <= '0;
                            state  <= S_WAIT;
                        end
                    end else if (accept) begin
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= rd_data;
                        if (dout_hit) begin
                            dout_set_o <= wb_dat_i[30] ? dout_onehot : '0;
                            dout_rst_o <= wb_dat_i[30] ? '0 : dout_onehot;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus_req) begin
                        state <= S_IDLE;
                    end else if (!sfifo_empty_i) begin
                        wb_ack_o   <= 1'b1;
                        wb_dat_o   <= head_data;
                        sfifo_rd_o <= 1'b1;
                        state      <= S_DONE;
                    end else if ((TIMEOUT_CYC > 0) && (to_cnt == TO_MAX)) begin
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= '0;
                        to_flag  <= 1'b1;
                        state    <= S_DONE;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Synchronise the async tick and count its rising edges. A held level counts once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bp_meta <= 1'b0;
            bp_sync <= 1'b0;
            bp_prev <= 1'b0;
            bp_cnt  <= '0;
        end else begin
            bp_meta <= sfifo_bp_tick_i;
            bp_sync <= bp_meta;
            bp_prev <= bp_sync;
            if (bp_sync && !bp_prev) begin
                bp_cnt <= bp_cnt + 32'd1;
            end
        end
    end

    // Synchronise DIN and latch rising edges. A new edge wins over a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            din_meta <= '0;
            din_sync <= '0;
            din_prev <= '0;
            dinr     <= '0;
        end else begin
            din_meta <= din_i;
            din_sync <= din_meta;
            din_prev <= din_sync;
            dinr     <= (dinr & ~dinr_clr) | (din_sync & ~din_prev);
        end
    end

endmodule

// File: tb/tb_sfifo_if_mc.sv
// tb_sfifo_if_mc: randomized scoreboard bench for sfifo_if_mc. Bus tasks push
// the expected response for each access, and a monitor compares it on every ack.
module tb_sfifo_if_mc;

    localparam int TO_CYC = 16;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wb_cyc_i  = 1'b0;
    logic        wb_stb_i  = 1'b0;
    logic        wb_we_i   = 1'b0;
    logic [3:0]  wb_sel_i  = 4'h0;
    logic [4:0]  wb_adr_i  = 5'd0;
    logic [31:0] wb_dat_i  = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        sfifo_rd_o;
    logic        sfifo_empty_i = 1'b1;
    logic [15:0] sfifo_di      = 16'h0;
    logic        sfifo_bp_tick_i = 1'b0;
    logic [7:0]  dout_set_o;
    logic [7:0]  dout_rst_o;
    logic [15:0] din_i = 16'h0;
    logic [23:0] adc_i = 24'h0;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    int exp_pops    = 0;
    int last_lat    = 0;

    logic [15:0] fifo_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_chk_q[$];
    logic [15:0] exp_pulse_q[$];
    string       exp_name_q[$];

    logic [31:0] bp_model   = 32'h0;
    logic [15:0] dinr_model = 16'h0;
    logic        to_model   = 1'b0;
    logic        prev_ack   = 1'b0;

    sfifo_if_mc #(
        .WB_AW(7), .WB_DW(32), .SFIFO_DW(16), .DOUT_N(8), .DIN_W(16),
        .ADC_N(2), .ADC_W(12), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .sfifo_rd_o(sfifo_rd_o), .sfifo_empty_i(sfifo_empty_i),
        .sfifo_di(sfifo_di), .sfifo_bp_tick_i(sfifo_bp_tick_i),
        .dout_set_o(dout_set_o), .dout_rst_o(dout_rst_o), .din_i(din_i), .adc_i(adc_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void fifoRefresh();
        sfifo_empty_i = (fifo_q.size() == 0);
        sfifo_di      = (fifo_q.size() == 0) ? 16'h0 : fifo_q[0];
    endfunction

    function automatic void fifoPush(input logic [15:0] w);
        fifo_q.push_back(w);
        fifoRefresh();
    endfunction

    // Expected DOUT pulse {set, rst} computed directly from the command fields.
    function automatic logic [15:0] doutExpect(input logic [31:0] d, input logic [3:0] s);
        int         idx;
        logic [7:0] bitv;
        idx = int'(d[29:24]);
        if (s[3] && d[31] && idx < 8) begin
            bitv = 8'(1 << idx);
            return d[30] ? {bitv, 8'h00} : {8'h00, bitv};
        end
        return 16'h0;
    endfunction

    // One bus access; pushes the expectation and waits (bounded) for the ack.
    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic chk, input logic [31:0] exp_d,
                                 input string name);
        int n;
        exp_data_q.push_back(exp_d);
        exp_chk_q.push_back(chk);
        exp_pulse_q.push_back(w ? ((a == 5'd3) ? doutExpect(d, s) : 16'h0) : 16'h0);
        exp_name_q.push_back(name);
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!wb_ack_o && n < 200);
        last_lat = n;
        if (!wb_ack_o) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_ack_timeout: got no ack after %0d cycles, expected ack", name, n);
            void'(exp_data_q.pop_back());
            void'(exp_chk_q.pop_back());
            void'(exp_pulse_q.pop_back());
            void'(exp_name_q.pop_back());
        end
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic bpPulse(input int len);
        @(posedge wb_clk_i);
        #1 sfifo_bp_tick_i = 1'b1;
        repeat (len) @(posedge wb_clk_i);
        #1 sfifo_bp_tick_i = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        bp_model = bp_model + 32'd1;
    endtask

    task automatic dinDrive(input logic [15:0] v);
        @(posedge wb_clk_i);
        #1;
        dinr_model = dinr_model | (v & ~din_i);
        din_i = v;
        repeat (4) @(posedge wb_clk_i);
    endtask

    // FIFO model pop, ack scoreboard and pulse/pop sanity checks, sampled on the falling edge.
    always @(negedge wb_clk_i) begin
        if (sfifo_rd_o) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifoRefresh();
        end
        if (wb_rst_ni) begin
            if (sfifo_rd_o && !wb_ack_o) checkOutput("pop_without_ack", 32'(sfifo_rd_o), 32'h0);
            if (!wb_ack_o && ({dout_set_o, dout_rst_o} != 16'h0))
                checkOutput("stray_dout_pulse", {16'h0, dout_set_o, dout_rst_o}, 32'h0);
            if (wb_ack_o) begin
                checkOutput("ack_single_cycle", 32'(prev_ack), 32'h0);
                if (exp_data_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wb_dat_o);
                end else begin
                    logic [31:0] ed;
                    logic        ec;
                    logic [15:0] ep;
                    string       en;
                    ed = exp_data_q.pop_front();
                    ec = exp_chk_q.pop_front();
                    ep = exp_pulse_q.pop_front();
                    en = exp_name_q.pop_front();
                    if (ec) checkOutput(en, wb_dat_o, ed);
                    checkOutput({en, "_dout"}, {16'h0, dout_set_o, dout_rst_o}, {16'h0, ep});
                end
            end
        end
        prev_ack = wb_ack_o;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [15:0] w;
        logic [3:0]  s;
        int          op;
        int          ch;
        int          unmapped[6];
        unmapped = '{6, 7, 10, 15, 20, 31};

        fifoRefresh();
        repeat (3) @(negedge wb_clk_i);
        checkOutput("reset_ack", 32'(wb_ack_o), 32'h0);
        checkOutput("reset_dat", wb_dat_o, 32'h0);
        checkOutput("reset_pop", 32'(sfifo_rd_o), 32'h0);
        checkOutput("reset_dout", {16'h0, dout_set_o, dout_rst_o}, 32'h0);
        @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;

        applyStimulus(1'b0, 5'd1, 32'h0, 4'hF, 1'b1, 32'h1, "stat_after_reset");
        checkOutput("ack_latency", last_lat, 2);
        applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, 32'h0, "bp_after_reset");

        fifoPush(16'hA5A5);
        exp_pops++;
        applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, 32'hA5A5_0000, "di_single");
        checkOutput("pops_single", pops, exp_pops);
        fifoPush(16'h1234);
        fifoPush(16'hBEEF);
        exp_pops += 2;
        applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, 32'h1234_0000, "di_first_of_two");
        applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, 32'hBEEF_0000, "di_second_of_two");
        checkOutput("pops_two", pops, exp_pops);

        applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, 32'h0, "di_timeout_data");
        to_model = 1'b1;
        checkOutput("di_timeout_wait_ok", 32'((last_lat >= TO_CYC + 1) && (last_lat <= TO_CYC + 4)), 32'h1);
        checkOutput("pops_after_timeout", pops, exp_pops);
        applyStimulus(1'b0, 5'd1, 32'h0, 4'hF, 1'b1, {30'h0, to_model, 1'b1}, "stat_timeout");
        applyStimulus(1'b1, 5'd1, 32'h2, 4'hF, 1'b0, 32'h0, "stat_w1c");
        to_model = 1'b0;
        applyStimulus(1'b0, 5'd1, 32'h0, 4'hF, 1'b1, {30'h0, to_model, 1'b1}, "stat_cleared");

        fork
            applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, 32'h5A5A_0000, "di_late_word");
            begin
                repeat (5) @(posedge wb_clk_i);
                #1 fifoPush(16'h5A5A);
            end
        join
        exp_pops++;
        checkOutput("pops_late_word", pops, exp_pops);

        applyStimulus(1'b1, 5'd3, 32'hC300_0000, 4'hF, 1'b0, 32'h0, "dout_set3");
        applyStimulus(1'b1, 5'd3, 32'h8300_0000, 4'hF, 1'b0, 32'h0, "dout_rst3");
        applyStimulus(1'b1, 5'd3, 32'h8A00_0000, 4'hF, 1'b0, 32'h0, "dout_idx10");
        applyStimulus(1'b1, 5'd3, 32'h4300_0000, 4'hF, 1'b0, 32'h0, "dout_disabled");

        dinDrive(16'h0004);
        applyStimulus(1'b0, 5'd4, 32'h0, 4'hF, 1'b1, 32'h4, "din_level");
        applyStimulus(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, {16'h0, dinr_model}, "dinr_edge");
        dinDrive(16'h0000);
        @(posedge wb_clk_i);
        #1 din_i = 16'h0004;
        @(posedge wb_clk_i);
        applyStimulus(1'b1, 5'd5, 32'h4, 4'hF, 1'b0, 32'h0, "dinr_w1c_race");
        dinr_model = (dinr_model & ~16'h0004) | 16'h0004;
        repeat (3) @(posedge wb_clk_i);
        applyStimulus(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, {16'h0, dinr_model}, "dinr_set_wins");
        applyStimulus(1'b1, 5'd5, 32'h4, 4'hF, 1'b0, 32'h0, "dinr_w1c");
        dinr_model = dinr_model & ~16'h0004;
        applyStimulus(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, {16'h0, dinr_model}, "dinr_cleared");

        for (int i = 0; i < 4; i++) bpPulse(1);
        bpPulse(10);
        applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "bp_five");

        @(negedge wb_clk_i);
        force dut.bp_cnt = 32'hFFFF_FFFE;
        @(negedge wb_clk_i);
        release dut.bp_cnt;
        bp_model = 32'hFFFF_FFFE;
        applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "bp_preload");
        bpPulse(2);
        bpPulse(3);
        applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "bp_wrap");

        adc_i = {12'hABC, 12'h123};
        applyStimulus(1'b0, 5'd9, 32'h0, 4'hF, 1'b1, 32'h0000_0ABC, "adc_ch1");
        applyStimulus(1'b0, 5'd8, 32'h0, 4'hF, 1'b1, 32'h0000_0123, "adc_ch0");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    d = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'($urandom), 6'($urandom_range(0, 15)), 24'($urandom)};
                    s = 4'($urandom);
                    applyStimulus(1'b1, 5'd3, d, s, 1'b0, 32'h0, "rnd_dout");
                end
                1: begin
                    w = 16'($urandom);
                    fifoPush(w);
                    exp_pops++;
                    applyStimulus(1'b0, 5'd2, 32'h0, 4'hF, 1'b1, {w, 16'h0}, "rnd_di");
                    checkOutput("rnd_pops", pops, exp_pops);
                end
                2: begin
                    dinDrive(16'($urandom));
                    applyStimulus(1'b0, 5'd4, 32'h0, 4'hF, 1'b1, {16'h0, din_i}, "rnd_din");
                    applyStimulus(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, {16'h0, dinr_model}, "rnd_dinr");
                    d = $urandom;
                    applyStimulus(1'b1, 5'd5, d, 4'hF, 1'b0, 32'h0, "rnd_dinr_w1c");
                    dinr_model = dinr_model & ~d[15:0];
                    applyStimulus(1'b0, 5'd5, 32'h0, 4'hF, 1'b1, {16'h0, dinr_model}, "rnd_dinr_after");
                end
                3: begin
                    adc_i = 24'($urandom);
                    ch = $urandom_range(0, 1);
                    applyStimulus(1'b0, 5'(8 + ch), 32'h0, 4'hF, 1'b1,
                                  (ch == 1) ? {20'h0, adc_i[23:12]} : {20'h0, adc_i[11:0]}, "rnd_adc");
                end
                4: begin
                    bpPulse($urandom_range(1, 6));
                    applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "rnd_bp");
                end
                default: begin
                    applyStimulus(1'b1, 5'd0, $urandom, 4'hF, 1'b0, 32'h0, "rnd_ro_write");
                    applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "rnd_ro_kept");
                    applyStimulus(1'b0, 5'(unmapped[$urandom_range(0, 5)]), 32'h0, 4'hF, 1'b1, 32'h0, "rnd_unmapped");
                end
            endcase
        end

        dinDrive(16'h0000);
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd2; wb_sel_i = 4'hF;
        repeat (6) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        checkOutput("reset_in_wait_ack", 32'(wb_ack_o), 32'h0);
        @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        bp_model   = 32'h0;
        dinr_model = 16'h0;
        to_model   = 1'b0;
        checkOutput("reset_in_wait_pops", pops, exp_pops);
        applyStimulus(1'b0, 5'd1, 32'h0, 4'hF, 1'b1, {30'h0, to_model, 1'b1}, "stat_after_wait_reset");
        applyStimulus(1'b0, 5'd0, 32'h0, 4'hF, 1'b1, bp_model, "bp_after_wait_reset");

        repeat (3) @(posedge wb_clk_i);
        checkOutput("scoreboard_drained", exp_data_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sfifo_if_mc.md
Name: sfifo_if_mc

Overview:
- Parametrised successor Wishbone slave bridging the CPU to the servo sync-FIFO, a bp_tick counter, multi-channel DOUT set/reset, DIN level/edge capture and N ADC channels.
- Adds a bounded wait-state on empty-FIFO reads (timeout with sticky error) and single-cycle DOUT pulses.
- Adds rising-edge latching of DIN with write-1-to-clear.
- Sits on the minsoc Wishbone bus in the clk_500 domain; bp_tick and DIN arrive asynchronously from clk_250.

Parameters:
- WB_AW, 7, Wishbone address width. Word address is wb_adr_i[WB_AW-1:2].
- WB_DW, 32, Wishbone data width.
- SFIFO_DW, 16, sync-FIFO data width (1..32).
- DOUT_N, 8, number of DOUT channels (1..64).
- DIN_W, 16, DIN width (1..32).
- ADC_N, 2, number of ADC channels (1..8).
- ADC_W, 12, ADC sample width (1..16).
- TIMEOUT_CYC, 1024, maximum wait cycles on an empty-FIFO read. 0 means wait forever. Counter width is clog2(TIMEOUT_CYC+1).

Ports:
- wb_clk_i  in  1  system clock (clk_500).
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects.
- wb_adr_i  in  WB_AW-2  word address [WB_AW-1:2].
- wb_dat_i  in  WB_DW  write data.
- wb_dat_o  out  WB_DW  read data.
- wb_ack_o  out  1  acknowledge.
- sfifo_rd_o  out  1  FIFO pop, one cycle per pop.
- sfifo_empty_i  in  1  FIFO empty.
- sfifo_di  in  SFIFO_DW  FIFO head word (first-word-fall-through, valid when !empty).
- sfifo_bp_tick_i  in  1  base-period tick level, async.
- dout_set_o  out  DOUT_N  one-hot set pulse.
- dout_rst_o  out  DOUT_N  one-hot reset pulse.
- din_i  in  DIN_W  digital inputs, async.
- adc_i  in  ADC_N*ADC_W  packed ADC samples; channel k is at [k*ADC_W +: ADC_W].

Behaviour:
- Reset (wb_rst_ni=0, async): all outputs 0, and all internal registers 0 except the synchroniser stages, which are also 0. The FSM goes to IDLE.
- Register map (word offsets):
  - 0x00 BP_CNT: RO, 32-bit tick count.
  - 0x04 STAT: bit0 = empty (RO); bit1 = TO sticky timeout, write 1 to clear.
  - 0x08 DI: read pops the FIFO; data in [31:32-SFIFO_DW], lower bits 0.
  - 0x0C DOUT: WO command.
  - 0x10 DIN: RO, synchronised level in [DIN_W-1:0].
  - 0x14 DINR: rising-edge latch; read returns the latch, a write with sel[0] clears bits where wb_dat_i=1.
  - 0x20+4k ADC_k, k < ADC_N: RO, zero-extended [ADC_W-1:0].
  - Unmapped offsets read 0. Writes to RO registers are acked and ignored.
- Handshake, non-DI access:
  - Ack one cycle after cyc&stb with wb_dat_o registered in the same edge.
  - Ack is high exactly 1 cycle (~ack guard). Back-to-back strobes give an ack every other cycle.
- DI read FSM (IDLE/WAIT/DONE):
  - IDLE: DI read with !empty → next edge ack=1, wb_dat_o=head, sfifo_rd_o=1, then DONE. With empty → WAIT, timeout counter cleared.
  - WAIT: empty deasserts → same pop/ack as IDLE, then DONE. Counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0) → ack=1, wb_dat_o=0, TO<=1, no pop, then DONE. cyc&stb drops → IDLE with no ack and no pop.
  - DONE: ack and sfifo_rd_o low; → IDLE. Exactly one pop per acked DI read.
  - A DI write is acked and has no effect.
- bp_tick:
  - 2-FF synchroniser, then rising-edge detect, then BP_CNT+1.
  - Wraps from 0xFFFFFFFF to 0.
  - A held-high tick counts once.
- DOUT command (write with sel[3] to 0x0C), wb_dat_i fields: [31]=en, [30]=val, [29:24]=idx.
  - en=1 and idx<DOUT_N: in the ack edge, set_o[idx]=val and rst_o[idx]=~val, for one cycle; both return to 0 the next cycle.
  - en=0 or idx>=DOUT_N: no pulse.
- DIN:
  - 2-FF synchroniser to din_s; DINR |= din_s & ~din_s_prev.
  - A set in the same cycle as a W1C on that bit wins (bit stays 1).
- ADC values are sampled directly with no synchroniser; the source holds them stable between updates.
- Reset asserted mid-DI-wait returns the FSM to IDLE with no ack.

Test Plan:
- Reset → all outputs 0; read 0x04 → 0x00000001 with FIFO empty; read 0x00 → 0.
- FIFO holds 0xA5A5 → read 0x08 → wb_dat_o=0xA5A50000, one sfifo_rd_o pulse, ack 1 cycle; two reads of 2 words give 2 pops total.
- Empty FIFO with TIMEOUT_CYC=16 → read 0x08: no ack for 16 cycles, then ack with 0, STAT=0x3, no pop. Write 0x2 to 0x04 → STAT=0x1. Variant: word arrives at cycle 5 → data acked and popped.
- Write 0xC3000000 to 0x0C → set_o=0x08 for 1 cycle. Write 0x83000000 → rst_o=0x08. Write 0x8A000000 with DOUT_N=8 → no pulse.
- din_i bit2 goes 0→1 → DIN=0x4 after 2 cycles, DINR=0x4. Write 0x4 to 0x14 in the same cycle as a new bit2 edge → DINR stays 0x4. A later W1C → 0.
- 5 bp_tick pulses (one held 10 cycles) → BP_CNT=5. Preload near wrap (force) → wraps to 0. adc_i ch1=0xABC → read 0x24 = 0x00000ABC.
